// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/op input handshake and result/flag output handshake for alu_pipe.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0] op;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] result;
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
    modport master (
        output in_valid, a, b, op, out_ready,
        input in_ready, out_valid, result, zero, carry, ovf, neg
    );
    modport slave (
        input in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, neg
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and zero/carry/ovf/neg flags.
// Define ALU_PIPE_MUL_EN to add an iterative shift-add multiplier on op 1100.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    logic [WIDTH:0] sum, diff;
    logic [WIDTH-1:0] res, wval, acc_nxt;
    logic [SHW-1:0] sh;
    logic fire, is_mul, mul_done, wr, c, v;
    assign sh = bus.b[SHW-1:0];
    assign sum = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign fire = bus.in_valid && bus.in_ready;
    always_comb begin
        res = '0;
        case (bus.op)
            4'b0000: res = sum[WIDTH-1:0];
            4'b0001: res = diff[WIDTH-1:0];
            4'b0010: res = bus.a & bus.b;
            4'b0011: res = bus.a | bus.b;
            4'b0100: res = WIDTH'(bus.a == bus.b);
            4'b0101: res = WIDTH'(bus.a < bus.b);
            4'b0110: res = bus.a ^ bus.b;
            4'b0111: res = ~(bus.a | bus.b);
            4'b1000: res = bus.a << sh;
            4'b1001: res = bus.a >> sh;
            4'b1010: res = $signed(bus.a) >>> sh;
            4'b1011: res = WIDTH'($signed(bus.a) < $signed(bus.b));
            default: res = '0;
        endcase
    end
    assign c = bus.op == 4'b0000 ? sum[WIDTH] : bus.op == 4'b0001 ? diff[WIDTH] : 1'b0;
    assign v = bus.op == 4'b0000 ? (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]) :
               bus.op == 4'b0001 ? (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]) : 1'b0;
`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    state_t state;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [SHW-1:0] cnt;
    logic last;
    assign is_mul = bus.op == 4'b1100;
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign last = cnt == SHW'(WIDTH - 1);
    assign mul_done = state == MUL && last && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = state == IDLE && (!bus.out_valid || bus.out_ready);
    // The final iteration waits in place until the output register can take the product.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
        end else if (fire && is_mul) begin
            state <= MUL;
            acc <= '0;
            mcand <= bus.a;
            mplier <= bus.b;
            cnt <= '0;
        end else if (state == MUL && (!last || mul_done)) begin
            acc <= acc_nxt;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + SHW'(1);
            if (last) state <= IDLE;
        end
`else
    assign is_mul = 1'b0;
    assign mul_done = 1'b0;
    assign acc_nxt = '0;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
`endif
    assign wr = (fire && !is_mul) || mul_done;
    assign wval = mul_done ? acc_nxt : res;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result <= '0;
            bus.zero <= 1'b1;
            bus.carry <= 1'b0;
            bus.ovf <= 1'b0;
            bus.neg <= 1'b0;
        end else if (wr) begin
            bus.out_valid <= 1'b1;
            bus.result <= wval;
            bus.zero <= wval == '0;
            bus.carry <= c && !mul_done;
            bus.ovf <= v && !mul_done;
            bus.neg <= wval[WIDTH-1];
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -MAXS - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    alu_pipe_if #(.WIDTH(32)) bus();
    alu_pipe #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint s = 0;
        int sh = int'(y % 32);
        logic [31:0] r = '0;
        logic cy = 1'b0;
        logic ov = 1'b0;
        case (o)
            4'd0: begin
                s = sx + sy;
                r = 32'(ux + uy);
                cy = ((ux + uy) >> 32) != 0;
                ov = s > MAXS || s < MINS;
            end
            4'd1: begin
                s = sx - sy;
                r = 32'(ux - uy);
                cy = ux < uy;
                ov = s > MAXS || s < MINS;
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = {31'b0, x == y};
            4'd5: r = {31'b0, ux < uy};
            4'd6: r = x ^ y;
            4'd7: r = ~(x | y);
            4'd8: r = x << sh;
            4'd9: r = x >> sh;
            4'd10: r = 32'(sx >>> sh);
            4'd11: r = {31'b0, sx < sy};
`ifdef ALU_PIPE_MUL_EN
            4'd12: r = 32'(ux * uy);
`endif
            default: r = '0;
        endcase
        return {r, r == 32'd0, cy, ov, r[31]};
    endfunction

    task automatic check(input string tag, input logic [36:0] exp);
        logic [36:0] obs = {bus.out_valid, bus.result, bus.zero, bus.carry, bus.ovf, bus.neg};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.op = o;
        #1 check_int("in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic op_chk(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        drive(x, y, o);
        check(tag, {1'b1, model(x, y, o)});
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic mul_run(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        int busy_bad = 0;
        drive(x, y, 4'd12);
        while (bus.out_valid !== 1'b1 && n < 100) begin
            if (bus.in_ready !== 1'b0) busy_bad = 1;
            n++;
            @(negedge clk);
        end
        check_int("mul_latency", n, 32);
        check_int("mul_busy", busy_bad, 0);
        check("mul", {1'b1, model(x, y, 4'd12)});
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y;
        logic [3:0] o;
        logic [36:0] exp;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        repeat (2) @(negedge clk);
        check("reset", {1'b0, 32'd0, 4'b1000});
        check_int("reset_in_ready", int'(bus.in_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        drive(23, 5, 4'd0);
        check("add", {1'b1, 32'd28, 4'b0000});
        drive(23, 5, 4'd1);
        check("stream_sub", {1'b1, 32'd18, 4'b0000});
        drive(23, 5, 4'd2);
        check("stream_and", {1'b1, 32'd5, 4'b0000});
        drive(23, 5, 4'd3);
        check("stream_or", {1'b1, 32'd23, 4'b0000});
        drive(5, 23, 4'd1);
        check("sub_borrow", {1'b1, 32'hFFFF_FFEE, 4'b0101});
        drive(5, 23, 4'd5);
        check("sltu", {1'b1, 32'd1, 4'b0000});
        drive(5, 23, 4'd4);
        check("eq_false", {1'b1, 32'd0, 4'b1000});
        drive(32'h7FFF_FFFF, 1, 4'd0);
        check("add_ovf", {1'b1, 32'h8000_0000, 4'b0011});
        drive(32'h8000_0000, 4, 4'd10);
        check("sra", {1'b1, 32'hF800_0000, 4'b0001});
        drive(32'h8000_0000, 1, 4'd1);
        check("sub_ovf", {1'b1, 32'h7FFF_FFFF, 4'b0010});
        drive(32'hFFFF_FFFF, 1, 4'd0);
        check("add_wrap", {1'b1, 32'd0, 4'b1100});
        drive(1, 32'h21, 4'd8);
        check("sll_lowbits", {1'b1, 32'd2, 4'b0000});
        drive(23, 5, 4'd13);
        check("unknown_op", {1'b1, 32'd0, 4'b1000});
`ifndef ALU_PIPE_MUL_EN
        drive(23, 5, 4'd12);
        check("mul_disabled", {1'b1, 32'd0, 4'b1000});
`endif
        drive(100, 50, 4'd0);
        check("bp_first", {1'b1, 32'd150, 4'b0000});
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 9;
        bus.b = 4;
        bus.op = 4'd1;
        repeat (3) begin
            @(negedge clk);
            check_int("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_hold", {1'b1, 32'd150, 4'b0000});
        end
        bus.out_ready = 1'b1;
        #1 check_int("bp_release_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next", {1'b1, 32'd5, 4'b0000});
        @(negedge clk);
        check_int("drain", int'(bus.out_valid), 0);
        repeat (300) begin
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? x : ($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom);
            o = 4'($urandom_range(0, 15));
`ifdef ALU_PIPE_MUL_EN
            if (o == 4'd12) o = 4'd0;
`endif
            exp = {1'b1, model(x, y, o)};
            drive(x, y, o);
            check("rand", exp);
            if ($urandom_range(0, 3) == 0) begin
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("rand_hold", exp);
                bus.out_ready = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                check_int("rand_gap", int'(bus.out_valid), 0);
            end
        end
`ifdef ALU_PIPE_MUL_EN
        mul_run(23, 5);
        check("mul_const", {1'b1, 32'd115, 4'b0000});
        repeat (3) mul_run($urandom, $urandom);
        drive(23, 5, 4'd12);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_int("mulrst_valid", int'(bus.out_valid), 0);
        check_int("mulrst_ready", int'(bus.in_ready), 1);
        repeat (40) @(negedge clk);
        check_int("mulrst_no_result", int'(bus.out_valid), 0);
        op_chk("after_mulrst", 7, 9, 4'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, parametrised-width ALU with valid/ready handshakes on input and output.
- Successor to the combinational datapath ALU: wider op set (shifts, XOR/NOR, signed compare), full flag set (zero/carry/overflow/negative), and an optional iterative multiplier.
- Sits between operand fetch and writeback of the datapath; tolerates writeback back-pressure.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), localparam: shift-amount width, taken from b[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand/op presented
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount
- op  in  4  operation select
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  add carry-out / sub borrow
- ovf  out  1  signed overflow (add/sub only)
- neg  out  1  result[WIDTH-1]

Behaviour:
- Reset: asynchronous, active-high. All outputs 0 except zero=1. State=IDLE. Any multiply in progress is aborted and discarded.
- Accept: transfer when in_valid && in_ready on a rising edge. Output transfer when out_valid && out_ready.
- in_ready:
  - In IDLE: (!out_valid || out_ready).
  - In MUL: 0.
- Single-cycle ops: result and flags are written at the accepting edge, so out_valid is high the following cycle (latency 1).
  - Simultaneous output take and new accept sustains 1 op/cycle with no bubble.
- Output hold: result and flags hold stable while out_valid && !out_ready. out_valid clears on a take with no new accept.
- Op encoding:
  - 0000 add a+b
  - 0001 sub a-b
  - 0010 and
  - 0011 or
  - 0100 eq: {0..,a==b}
  - 0101 sltu: {0..,a<b unsigned}
  - 0110 xor
  - 0111 nor
  - 1000 sll a<<b[SHW-1:0]
  - 1001 srl
  - 1010 sra (arithmetic)
  - 1011 slt: {0..,a<b signed}
  - 1100 mul (optional feature)
  - 1101-1111 result 0
- Flags:
  - zero = (result==0) for every op.
  - neg = result MSB.
  - carry: add = bit WIDTH of the (WIDTH+1)-bit sum; sub = 1 when a<b unsigned (borrow); 0 for all other ops.
  - ovf: add = (a,b same sign) && result sign differs; sub = (a,b different sign) && result sign != a sign; 0 for all other ops.
- Wrap-around: add/sub truncate to WIDTH bits. Shift amount uses only the low SHW bits of b.
- State machine: IDLE, MUL (MUL exists only with the feature).
  - IDLE -> MUL on accept of op 1100.
  - MUL -> IDLE after the final iteration.
- Unknown op: completes in 1 cycle with result 0, zero=1; no error signalled.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined:
  - op 1100 runs a shift-add unsigned multiply, one partial product per cycle.
  - The accepting edge loads the operands and enters MUL; WIDTH further edges perform the iterations.
  - The last iteration's edge writes the low WIDTH product bits to result, sets out_valid, returns to IDLE.
  - First result-valid cycle is WIDTH+1 cycles after the accept edge's cycle; the result is the product mod 2^WIDTH.
  - carry=0, ovf=0; zero and neg follow result.
  - If out_valid is still held when MUL completes, the iteration stalls in its final state until the output register frees.
  - Reset during MUL returns to IDLE with out_valid=0.
- Undefined: no MUL state or multiplier logic; op 1100 behaves as an unknown op (1 cycle, result 0, zero=1).

Test Plan:
- Reset, then a=23, b=5, op=0000, out_ready=1 -> next cycle result=28, zero=0, carry=0, ovf=0.
- Back-to-back stream, op=0001 then 0010 then 0011 (a=23, b=5), out_ready=1 -> results 18, 5, 23 on consecutive cycles; in_ready stays 1.
- a=5, b=23, op=0001 -> result=0xFFFFFFEE, carry=1, neg=1. Then op=0101 -> result=1; op=0100 -> result=0, zero=1.
- a=0x7FFFFFFF, b=1, op=0000 -> result=0x80000000, ovf=1, neg=1, carry=0. Then a=0x80000000, b=4, op=1010 -> 0xF8000000.
- Back-pressure: out_ready=0 for 3 cycles after an add -> in_ready=0, result and flags stable. out_ready=1 -> in_ready=1 and a new op is accepted the same cycle.
- With ALU_PIPE_MUL_EN, a=23, b=5, op=1100 -> in_ready=0 for 32 cycles, then result=115. Assert rst mid-multiply -> out_valid=0, in_ready=1 after reset release.
